shift_sched: RTL
================

# shift_sched

Round-robin scheduler that shares the ALU's single 8-bit logical left shifter between two requesters. The shift result is captured in a one-entry output register with valid/ready back-pressure. Each result is tagged with the index of the requester that issued it. Per-requester completion counters are provided for debug and performance readout. The block sits between the ALU issue logic and the shared `shiftleft` datapath.

## Interface
- `PRIO_RESET`, default 0: requester that holds round-robin priority after reset (0 or 1).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in0_valid`  in  1  requester 0 has an operation pending.
- `in0_ready`  out  1  requester 0 operation accepted this cycle.
- `in0_a`  in  8  requester 0 operand.
- `in0_shift`  in  3  requester 0 shift amount (0–7).
- `in1_valid`, `in1_ready`, `in1_a`, `in1_shift`: same as requester 0, for requester 1.
- `out_valid`  out  1  result register holds an undelivered result.
- `out_ready`  in  1  consumer accepts the result this cycle.
- `out_data`  out  8  `(a << shift) & 8'hFF` of the granted operation.
- `out_src`  out  1  index of the requester that produced `out_data`.
- `cnt0`, `cnt1`  out  8 each  number of results delivered (out_valid & out_ready) per requester, modulo 256.

## Operation
- Slot free condition: `free = !out_valid || out_ready`. A new operation may enter while the current result drains in the same cycle.
- Arbitration when `free` is high:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester selected by priority pointer `rr` is granted.
  - Neither valid: no grant.
- `free` low: no grant; both `inK_ready` are 0.
- `inK_ready` is high only for the granted requester. Acceptance is `inK_valid & inK_ready`.
- At most one acceptance per cycle.
- Priority update: after a grant to requester k, `rr` becomes `~k`. With no grant, `rr` holds.
- On acceptance, the granted operand and shift amount drive the shifter combinationally. The result and `out_src = k` are registered, and `out_valid` is set.
- Shift semantics: logical left shift, zero fill, width 8, bits shifted past bit 7 discarded. Shift 0 passes the operand unchanged.
- Output register states:
  - EMPTY (`out_valid=0`).
  - FULL (`out_valid=1`).
  - EMPTY → FULL on acceptance.
  - FULL → EMPTY on `out_ready` with no acceptance.
  - FULL → FULL on `out_ready` with acceptance: new data replaces old in the same edge.
  - FULL with `out_ready=0`: `out_data`/`out_src` held stable.
- Counters: `cnt[out_src]` increments by 1 on each delivery (`out_valid & out_ready`). Wraps 255 → 0.
- Requester rules: must hold `valid`, `a` and `shift` stable until accepted. Must not make `valid` depend on `ready`.

## Timing
- Latency: accept in cycle N, result on `out_data` with `out_valid=1` from cycle N+1.
- Throughput: 1 result per cycle while `out_ready` stays high.
- `inK_ready` is combinational from `inK_valid`, the other requester's valid, `out_valid`, `out_ready` and `rr`.
- No combinational path from any input to `out_valid`, `out_data`, `out_src`, `cnt0` or `cnt1`. All of these are registered.
- Reset, in any cycle including mid-transfer:
  - Outputs: `out_valid=0`, `out_data=8'h00`, `out_src=0`, `cnt0=cnt1=0`, `rr=PRIO_RESET`.
  - `inK_ready=0` during the reset cycle.
  - A pending result is discarded and is not counted.
- First cycle after reset deassertion: grants are possible immediately.

## Structure
- Shared ALU package holds:
  - `SHIFT_W=8` (data width) and `SHAMT_W=3` (shift-amount width) constants.
  - Requester index encoding (`SRC_0=0`, `SRC_1=1`).
- One sub-module: the existing `shiftleft` datapath, instantiated once. Its inputs are muxed from the granted requester.
- Arbiter, output register and counters live in `shift_sched` itself; no further sub-modules.

## Test plan
- Single request: in0 `a=8'hB5`, `shift=3`, `out_ready=1` → in0_ready in cycle N, `out_data=8'hA8`, `out_src=0` in N+1; `cnt0=1` after delivery.
- Contention: both valid every cycle from reset, `PRIO_RESET=0`, `out_ready=1` → grants alternate 0,1,0,1. In0 `a=8'h01`, `shift=7` gives `8'h80`. In1 `a=8'hFF`, `shift=0` gives `8'hFF`.
- Back-pressure: result FULL with `out_ready=0` for 4 cycles while both request → both readies 0, `out_data` stable. Then `out_ready=1` → delivery and a new acceptance in the same cycle; `out_valid` stays 1.
- Counter wrap: 256 deliveries from in1 → `cnt1` returns to 0, `cnt0` stays 0.
- Reset mid-operation: `rst=1` while FULL with `out_ready=0` → next cycle `out_valid=0`, counters 0, `rr=PRIO_RESET`. The discarded result is never delivered.
- Sweep: every `shift` 0–7 with `a=8'hFF` → `out_data` = `FF, FE, FC, F8, F0, E0, C0, 80`.

Source files
------------

// File: rtl/shift_sched_pkg.sv
// Shared ALU definitions for the shift scheduler: widths, requester index
// encoding, output register states and the operand bundle routed to the
// shared shifter.
package shift_sched_pkg;

  // Datapath width of the shared shifter and width of its shift amount.
  localparam int SHIFT_W = 8;
  localparam int SHAMT_W = 3;

  // Requester index encoding; also the value carried on out_src.
  typedef enum logic {
    SRC_0 = 1'b0,
    SRC_1 = 1'b1
  } src_e;

  // One-entry result register occupancy.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Operation presented to the shifter by the granted requester.
  typedef struct packed {
    logic [SHIFT_W-1:0] a;
    logic [SHAMT_W-1:0] shamt;
  } shift_op_t;

  // Round-robin helper: after serving one requester, the other gets priority.
  function automatic src_e other_src(input src_e k);
    return (k == SRC_0) ? SRC_1 : SRC_0;
  endfunction

endpackage

// File: rtl/shift_sched_shiftleft.sv
// Shared ALU logical left shifter: zero fill, bits past the MSB discarded.
// Purely combinational, three log-stages (1, 2, 4 positions).
// No state and no handshake; the caller muxes the operand in.
module shiftleft
  import shift_sched_pkg::*;
(
  input  logic [SHIFT_W-1:0] a_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic [SHIFT_W-1:0] y_o
);

  logic [SHIFT_W-1:0] stage1;
  logic [SHIFT_W-1:0] stage2;
  logic [SHIFT_W-1:0] stage4;

  // Log shifter: each shift-amount bit conditionally moves the word by 2^i.
  always_comb begin
    stage1 = shamt_i[0] ? {a_i[SHIFT_W-2:0], 1'b0}       : a_i;
    stage2 = shamt_i[1] ? {stage1[SHIFT_W-3:0], 2'b00}   : stage1;
    stage4 = shamt_i[2] ? {stage2[SHIFT_W-5:0], 4'b0000} : stage2;
    y_o    = stage4;
  end

endmodule

// File: rtl/shift_sched.sv
// Round-robin scheduler sharing one left shifter between two requesters,
// with a one-entry tagged result register and per-requester delivery counters.
// Latency 1 cycle accept->result; 1 result/cycle; input ready drops when the result slot is full and not draining.
module shift_sched
  import shift_sched_pkg::*;
#(
  parameter logic PRIO_RESET = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  // Requester 0
  input  logic               in0_valid,
  output logic               in0_ready,
  input  logic [SHIFT_W-1:0] in0_a,
  input  logic [SHAMT_W-1:0] in0_shift,
  // Requester 1
  input  logic               in1_valid,
  output logic               in1_ready,
  input  logic [SHIFT_W-1:0] in1_a,
  input  logic [SHAMT_W-1:0] in1_shift,
  // Result
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SHIFT_W-1:0] out_data,
  output logic               out_src,
  // Debug / performance counters
  output logic [7:0]         cnt0,
  output logic [7:0]         cnt1
);

  localparam src_e RR_RESET = src_e'(PRIO_RESET);

  // Registered state
  out_state_e         state_q;
  logic [SHIFT_W-1:0] data_q;
  src_e               src_q;
  src_e               rr_q;
  src_e               rr_d;
  logic [7:0]         cnt0_q;
  logic [7:0]         cnt0_d;
  logic [7:0]         cnt1_q;
  logic [7:0]         cnt1_d;

  // Arbitration and datapath
  logic               slot_free;
  logic               gnt0;
  logic               gnt1;
  logic               accept;
  logic               deliver;
  src_e               grant_src;
  shift_op_t          op_sel;
  logic [SHIFT_W-1:0] shift_res;

  // Slot is free when empty or when the held result leaves this cycle.
  assign slot_free = (state_q == OUT_EMPTY) || out_ready;
  assign deliver   = (state_q == OUT_FULL) && out_ready;

  // Grant selection: lone requester wins; on contention the pointer decides.
  // Nothing is granted while reset is asserted so no request is consumed.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && slot_free) begin
      if (in0_valid && in1_valid) begin
        if (rr_q == SRC_1) gnt1 = 1'b1;
        else               gnt0 = 1'b1;
      end else if (in0_valid) begin
        gnt0 = 1'b1;
      end else if (in1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  // A grant is only raised for a valid requester, so grant == acceptance.
  assign in0_ready = gnt0;
  assign in1_ready = gnt1;
  assign accept    = gnt0 | gnt1;
  assign grant_src = gnt1 ? SRC_1 : SRC_0;

  // Operand mux feeding the shared shifter from the granted requester.
  always_comb begin
    op_sel = '0;
    if (gnt1) begin
      op_sel.a     = in1_a;
      op_sel.shamt = in1_shift;
    end else begin
      op_sel.a     = in0_a;
      op_sel.shamt = in0_shift;
    end
  end

  shiftleft u_shiftleft (
    .a_i     (op_sel.a),
    .shamt_i (op_sel.shamt),
    .y_o     (shift_res)
  );

  // Priority pointer next state: hand priority to the other side after a grant.
  always_comb begin
    rr_d = rr_q;
    if (accept) rr_d = other_src(grant_src);
  end

  // Counter next state: count deliveries against the tag of the leaving result.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (deliver) begin
      if (src_q == SRC_1) cnt1_d = cnt1_q + 8'd1;
      else                cnt0_d = cnt0_q + 8'd1;
    end
  end

  // Result register FSM: load on acceptance (even while draining), empty on a
  // delivery with nothing new behind it, otherwise hold data and tag stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OUT_EMPTY;
      data_q  <= '0;
      src_q   <= SRC_0;
    end else begin
      case (state_q)
        OUT_EMPTY: begin
          if (accept) begin
            state_q <= OUT_FULL;
            data_q  <= shift_res;
            src_q   <= grant_src;
          end
        end
        OUT_FULL: begin
          if (accept) begin
            state_q <= OUT_FULL;
            data_q  <= shift_res;
            src_q   <= grant_src;
          end else if (out_ready) begin
            state_q <= OUT_EMPTY;
          end
        end
        default: begin
          state_q <= OUT_EMPTY;
        end
      endcase
    end
  end

  // Arbitration pointer and delivery counters; a discarded result is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q   <= RR_RESET;
      cnt0_q <= 8'd0;
      cnt1_q <= 8'd0;
    end else begin
      rr_q   <= rr_d;
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign out_valid = (state_q == OUT_FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;

endmodule
